// File: rtl/i2c_slave_reg_wr.sv
// Write-only I2C slave: oversamples SCL/SDA on clk and turns
// START / dev addr / reg addr / data... / STOP sequences into register-file write strobes.
module i2c_slave_reg_wr #(
  parameter logic [6:0] DEV_ADDR    = 7'h0A,
  parameter int         NUM_REGS    = 128,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       busy,
  output logic       err_nack
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEV_ADDR = 3'd1,
    S_DEV_ACK  = 3'd2,
    S_REG_ADDR = 3'd3,
    S_REG_ACK  = 3'd4,
    S_DATA     = 3'd5,
    S_DATA_ACK = 3'd6,
    S_IGNORE   = 3'd7
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_h_q, scl_h_d;
  logic                   sda_h_q, sda_h_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_rdy_q, byte_rdy_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       reg_wr_en_q, reg_wr_en_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       busy_q, busy_d;
  logic       err_nack_q, err_nack_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;
  logic dev_match, reg_in_range, ptr_in_range;

  // Synchronizer chains shift toward the MSB; the MSB is the clean sample.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_h_d    = scl_s;
    sda_h_d    = sda_s;
  end

  // START/STOP need SCL steady high across the sample; an SDA edge coincident
  // with an SCL edge is treated as an ordinary data change.
  assign scl_rise  =  scl_s & ~scl_h_q;
  assign scl_fall  = ~scl_s &  scl_h_q;
  assign sda_rise  =  sda_s & ~sda_h_q;
  assign sda_fall  = ~sda_s &  sda_h_q;
  assign start_det = sda_fall & scl_s & scl_h_q;
  assign stop_det  = sda_rise & scl_s & scl_h_q;

  assign dev_match    = (shift_q == {DEV_ADDR, 1'b0});
  assign reg_in_range = ({1'b0, shift_q} < 9'(NUM_REGS));
  assign ptr_in_range = ({1'b0, ptr_q} < 9'(NUM_REGS));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_rdy_d  = byte_rdy_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    reg_wr_en_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    busy_d      = busy_q;
    err_nack_d  = 1'b0;

    if (start_det) begin
      state_d    = S_DEV_ADDR;
      bit_cnt_d  = 3'd0;
      shift_d    = 8'h00;
      byte_rdy_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b1;
    end else if (stop_det) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 3'd0;
      shift_d    = 8'h00;
      byte_rdy_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_REG_ADDR, S_DATA: begin
          if (scl_rise && !byte_rdy_q) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_rdy_d = 1'b1;
          end else if (scl_fall && byte_rdy_q) begin
            // SCL fall after the 8th bit opens the ACK slot.
            byte_rdy_d = 1'b0;
            bit_cnt_d  = 3'd0;
            case (state_q)
              S_DEV_ADDR: begin
                if (dev_match) begin
                  sda_oe_d = 1'b1;
                  state_d  = S_DEV_ACK;
                end else begin
                  err_nack_d = 1'b1;
                  state_d    = S_IGNORE;
                end
              end
              S_REG_ADDR: begin
                ptr_d = shift_q;
                if (reg_in_range) begin
                  sda_oe_d = 1'b1;
                  state_d  = S_REG_ACK;
                end else begin
                  err_nack_d = 1'b1;
                  state_d    = S_IGNORE;
                end
              end
              default: begin
                if (ptr_in_range) begin
                  reg_wr_en_d = 1'b1;
                  reg_addr_d  = ptr_q;
                  reg_wdata_d = shift_q;
                  ptr_d       = ptr_q + 8'd1;
                  sda_oe_d    = 1'b1;
                  state_d     = S_DATA_ACK;
                end else begin
                  err_nack_d = 1'b1;
                  state_d    = S_IGNORE;
                end
              end
            endcase
          end
        end
        S_DEV_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_REG_ADDR;
          end
        end
        S_REG_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_DATA;
          end
        end
        S_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_h_q     <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_rdy_q  <= 1'b0;
      ptr_q       <= 8'h00;
      sda_oe_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      err_nack_q  <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_h_q     <= scl_h_d;
      sda_h_q     <= sda_h_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_rdy_q  <= byte_rdy_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      err_nack_q  <= err_nack_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = busy_q;
  assign err_nack  = err_nack_q;

endmodule

// File: tb/tb_i2c_slave_reg_wr.sv
// Directed bench for i2c_slave_reg_wr: a bit-banged master on a wired-AND SDA,
// with strobes collected into a queue and compared against hand-computed writes.
module tb_i2c_slave_reg_wr;

  localparam int Q = 5;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       busy;
  logic       err_nack;

  int n_checks;
  int n_errors;
  int err_cnt;
  int both_cnt;
  int ack_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_reg_wr dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_wr_en (reg_wr_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .busy      (busy),
    .err_nack  (err_nack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe and NACK monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) got_q.push_back({reg_addr, reg_wdata});
      if (err_nack) err_cnt++;
      if (reg_wr_en && err_nack) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic i2c_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_ack(output logic ack);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = sda_oe;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    i2c_ack(ack);
    if (ack) ack_cnt++;
  endtask

  // scoreboard: compare collected strobes with exp_q, then clear both
  task automatic expect_writes(input string tag);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  logic [7:0] data11[11];

  initial begin
    logic ack;
    int   e0;
    data11 = '{8'hFF, 8'hFD, 8'hDF, 8'h00, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22};
    n_checks = 0; n_errors = 0; err_cnt = 0; both_cnt = 0; ack_cnt = 0;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    check("reset_outs", {sda_oe, reg_wr_en, reg_addr, reg_wdata, busy, err_nack}, 0);
    rst = 1'b0;
    tick(4);

    // full burst with auto-increment
    ack_cnt = 0; e0 = err_cnt;
    i2c_start();
    check("burst_busy", busy, 1);
    i2c_byte(8'h14, ack);
    i2c_byte(8'h12, ack);
    for (int i = 0; i < 11; i++) begin
      i2c_byte(data11[i], ack);
      exp_q.push_back({8'(8'h12 + i), data11[i]});
    end
    i2c_stop();
    check("burst_acks", ack_cnt, 13);
    check("burst_err", err_cnt - e0, 0);
    check("burst_idle", busy, 0);
    check("burst_hold_addr", reg_addr, 8'h1C);
    check("burst_hold_data", reg_wdata, 8'h22);
    expect_writes("burst");

    // wrong device address
    e0 = err_cnt;
    i2c_start();
    i2c_byte(8'h16, ack);
    check("badaddr_ack", ack, 0);
    i2c_stop();
    check("badaddr_err", err_cnt - e0, 1);
    check("badaddr_busy", busy, 0);
    expect_writes("badaddr");

    // read request is refused; following bytes stay ignored
    e0 = err_cnt;
    i2c_start();
    i2c_byte(8'h15, ack);
    check("read_ack", ack, 0);
    i2c_byte(8'h14, ack);
    check("read_ignore_ack", ack, 0);
    check("read_ignore_busy", busy, 1);
    i2c_stop();
    check("read_err", err_cnt - e0, 1);
    expect_writes("read");

    // register address out of range
    e0 = err_cnt;
    i2c_start();
    i2c_byte(8'h14, ack);
    i2c_byte(8'h80, ack);
    check("regoor_ack", ack, 0);
    i2c_byte(8'h11, ack);
    i2c_stop();
    check("regoor_err", err_cnt - e0, 1);
    expect_writes("regoor");

    // pointer runs off the end
    e0 = err_cnt;
    i2c_start();
    i2c_byte(8'h14, ack);
    i2c_byte(8'h7F, ack);
    check("end_reg_ack", ack, 1);
    i2c_byte(8'hAA, ack);
    check("end_d0_ack", ack, 1);
    i2c_byte(8'hBB, ack);
    check("end_d1_ack", ack, 0);
    i2c_stop();
    check("end_err", err_cnt - e0, 1);
    exp_q.push_back(16'h7FAA);
    expect_writes("end");

    // repeated START after register address
    i2c_start();
    i2c_byte(8'h14, ack);
    i2c_byte(8'h20, ack);
    i2c_start();
    i2c_byte(8'h14, ack);
    i2c_byte(8'h05, ack);
    i2c_byte(8'h5A, ack);
    check("rstart_ack", ack, 1);
    i2c_stop();
    exp_q.push_back(16'h055A);
    expect_writes("rstart");

    // STOP after half a data byte
    i2c_start();
    i2c_byte(8'h14, ack);
    i2c_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1);
    i2c_stop();
    check("halfstop_outs", {sda_oe, busy}, 0);
    expect_writes("halfstop");

    // reset during the 4th data byte
    i2c_start();
    i2c_byte(8'h14, ack);
    i2c_byte(8'h40, ack);
    i2c_byte(8'h01, ack);
    i2c_byte(8'h02, ack);
    i2c_byte(8'h03, ack);
    exp_q.push_back(16'h4001);
    exp_q.push_back(16'h4102);
    exp_q.push_back(16'h4203);
    i2c_bit(1'b1); i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_outs", {sda_oe, reg_wr_en, reg_addr, reg_wdata, busy, err_nack}, 0);
    i2c_bit(1'b0); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b1);
    i2c_ack(ack);
    check("midrst_ack", ack, 0);
    i2c_byte(8'h14, ack);
    check("midrst_ack2", ack, 0);
    check("midrst_busy", busy, 0);
    i2c_stop();
    expect_writes("midrst");

    check("wr_and_nack_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
